// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_adder_ctrl_if                                            |
// | Brief    : Request/result bundle for the bit-serial adder controller.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface serial_adder_ctrl_if #(
    parameter int W = 8
) ();
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    modport master (
        output start, a, b, cin,
        input  sum, cout, busy, done
    );

    modport slave (
        input  start, a, b, cin,
        output sum, cout, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_adder_ctrl (+ full_adder_struct)                         |
// | Brief    : W-bit adder that reuses one full adder over W cycles, LSB first.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

module full_adder_struct (
    input  wire a,
    input  wire b,
    input  wire cin,
    output wire sum,
    output wire cout
);
    wire w_axb;
    wire w_ab;
    wire w_cx;

    xor u_x1 (w_axb, a, b);
    xor u_x2 (sum, w_axb, cin);
    and u_a1 (w_ab, a, b);
    and u_a2 (w_cx, cin, w_axb);
    or  u_o1 (cout, w_ab, w_cx);
endmodule

module serial_adder_ctrl #(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CW = $clog2(W) + 1;

    localparam logic [1:0]    c_s_idle  = 2'd0;
    localparam logic [1:0]    c_s_run   = 2'd1;
    localparam logic [1:0]    c_s_done  = 2'd2;
    localparam logic [CW-1:0] c_cnt_one = CW'(1);
    localparam logic [CW-1:0] c_cnt_end = CW'(W - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [W-1:0]  r_sh_a;
    logic [W-1:0]  r_sh_b;
    logic [W-1:0]  r_sh_s;
    logic [W-1:0]  w_sh_s_nxt;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_sum;
    logic          r_cout;
    logic          w_fa_sum;
    logic          w_fa_cout;
    logic          w_last;

    full_adder_struct u_fa (
        .a    (r_sh_a[0]),
        .b    (r_sh_b[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    assign w_last = (r_cnt == c_cnt_end);

    // The sum bit enters at the MSB so that after W shifts bit 0 sits at the LSB.
    generate
        if (W == 1) begin : g_w1
            assign w_sh_s_nxt = w_fa_sum;
        end else begin : g_wn
            assign w_sh_s_nxt = {w_fa_sum, r_sh_s[W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_s_idle: if (bus.start) w_state_nxt = c_s_run;
            c_s_run:  if (w_last)    w_state_nxt = c_s_done;
            c_s_done:                w_state_nxt = c_s_idle;
            default:                 w_state_nxt = c_s_idle;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            c_s_run:  bus.busy = 1'b1;
            c_s_done: bus.done = 1'b1;
            default: ;
        endcase
    end

    // Result registers are written only on the final bit so they hold steady during RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_sh_s  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    if (bus.start) begin
                        r_sh_a  <= bus.a;
                        r_sh_b  <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                    end
                end
                c_s_run: begin
                    r_carry <= w_fa_cout;
                    r_sh_a  <= r_sh_a >> 1;
                    r_sh_b  <= r_sh_b >> 1;
                    r_sh_s  <= w_sh_s_nxt;
                    r_cnt   <= r_cnt + c_cnt_one;
                    if (w_last) begin
                        r_sum  <= w_sh_s_nxt;
                        r_cout <= w_fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_serial_adder_ctrl                                            |
// | Brief    : Directed scoreboard bench for W=8 and W=1 serial adders.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_serial_adder_ctrl;
    typedef struct {
        logic [64:0] exp;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q8[$];
    exp_t q1[$];
    logic [8:0] last8 = '0;

    serial_adder_ctrl_if #(.W(8)) b8 ();
    serial_adder_ctrl_if #(.W(1)) b1 ();

    serial_adder_ctrl #(.W(8)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    serial_adder_ctrl #(.W(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) begin
        if (rst_n && !b8.busy && !b8.done)
            assert (!$isunknown(b8.start)) else $error("start unknown in IDLE (W=8)");
        if (rst_n && !b1.busy && !b1.done)
            assert (!$isunknown(b1.start)) else $error("start unknown in IDLE (W=1)");
    end

    // Scoreboard monitors: every done pulse must match the oldest pending expectation.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (b8.done === 1'b1) begin
            if (q8.size() == 0) chk("d8_spurious_done", 1, 0);
            else begin
                e = q8.pop_front();
                chk("d8_result", {b8.cout, b8.sum}, e.exp);
                chk("d8_latency", cyc, e.cyc + 1 + 8);
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (b1.done === 1'b1) begin
            if (q1.size() == 0) chk("d1_spurious_done", 1, 0);
            else begin
                e = q1.pop_front();
                chk("d1_result", {b1.cout, b1.sum}, e.exp);
                chk("d1_latency", cyc, e.cyc + 1 + 1);
            end
        end
    end

    task automatic wait_idle8();
        int n = 0;
        @(negedge clk);
        while ((b8.busy || b8.done) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("d8_idle_timeout", 1, 0);
    endtask

    task automatic wait_idle1();
        int n = 0;
        @(negedge clk);
        while ((b1.busy || b1.done) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("d1_idle_timeout", 1, 0);
    endtask

    // poke: busy cycle at which a stray start is raised; abort: busy cycle at which reset hits.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic [8:0] exp, input int poke, input int abort_at);
        int bc = 0;
        wait_idle8();
        b8.start = 1'b1; b8.a = ta; b8.b = tb; b8.cin = tc;
        q8.push_back('{exp: 65'(exp), cyc: cyc});
        @(negedge clk);
        b8.start = 1'b0;
        while (b8.busy && bc < 20) begin
            bc++;
            if (bc == 2) chk("d8_sum_stable_run", {b8.cout, b8.sum}, last8);
            if (bc == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("d8_abort_busy", b8.busy, 0);
                chk("d8_abort_done", b8.done, 0);
                chk("d8_abort_result", {b8.cout, b8.sum}, 0);
                q8.delete();
                last8 = '0;
                @(negedge clk);
                rst_n = 1'b1;
                repeat (12) @(negedge clk);
                return;
            end
            b8.a = ~b8.a; b8.b = b8.b + 8'h11; b8.cin = ~b8.cin;
            b8.start = (bc == poke);
            if (bc == poke) begin
                b8.a = 8'h01; b8.b = 8'h01;
            end
            @(negedge clk);
        end
        b8.start = 1'b0;
        chk("d8_busy_cycles", bc, 8);
        chk("d8_done_high", b8.done, 1);
        @(negedge clk);
        chk("d8_done_one_cycle", b8.done, 0);
        last8 = exp;
    endtask

    task automatic op1(input logic ta, input logic tb, input logic tc, input logic [1:0] exp);
        int n = 0;
        wait_idle1();
        b1.start = 1'b1; b1.a = ta; b1.b = tb; b1.cin = tc;
        q1.push_back('{exp: 65'(exp), cyc: cyc});
        @(negedge clk);
        b1.start = 1'b0;
        chk("d1_busy", b1.busy, 1);
        while (!b1.done && n < 10) begin
            n++;
            @(negedge clk);
        end
        if (n >= 10) chk("d1_done_timeout", 1, 0);
    endtask

    initial begin
        int nd = 0;
        int n = 0;
        b8.start = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0;
        b1.start = 1'b0; b1.a = '0; b1.b = '0; b1.cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("d8_reset_state", {b8.busy, b8.done, b8.cout, b8.sum}, 0);
        chk("d1_reset_state", {b1.busy, b1.done, b1.cout, b1.sum}, 0);
        rst_n = 1'b1;

        op8(8'h5A, 8'h3C, 1'b0, 9'h096, 0, 0);
        op8(8'hFF, 8'h01, 1'b0, 9'h100, 0, 0);
        op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, 0, 0);
        op8(8'h00, 8'h00, 1'b0, 9'h000, 0, 0);
        op8(8'hA5, 8'h0F, 1'b1, 9'h0B5, 3, 0);
        op8(8'h12, 8'h34, 1'b0, 9'h046, 0, 4);
        op8(8'h12, 8'h34, 1'b0, 9'h046, 0, 0);

        // Start held high: a second operation begins as soon as IDLE is re-entered.
        wait_idle8();
        b8.start = 1'b1; b8.a = 8'h80; b8.b = 8'h80; b8.cin = 1'b1;
        q8.push_back('{exp: 65'h101, cyc: cyc});
        q8.push_back('{exp: 65'h101, cyc: cyc + 8 + 2});
        while (nd < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (b8.done) nd++;
        end
        b8.start = 1'b0;
        chk("d8_held_start_dones", nd, 2);

        op1(1'b0, 1'b0, 1'b0, 2'b00);
        op1(1'b0, 1'b0, 1'b1, 2'b01);
        op1(1'b0, 1'b1, 1'b0, 2'b01);
        op1(1'b0, 1'b1, 1'b1, 2'b10);
        op1(1'b1, 1'b0, 1'b0, 2'b01);
        op1(1'b1, 1'b0, 1'b1, 2'b10);
        op1(1'b1, 1'b1, 1'b0, 2'b10);
        op1(1'b1, 1'b1, 1'b1, 2'b11);

        repeat (15) @(negedge clk);
        chk("d8_queue_drained", q8.size(), 0);
        chk("d1_queue_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
